// File: rtl/pau_arbiter.sv
// pau_arbiter: round-robin sharing of one posit arithmetic unit among NUM_REQ
// requesters. One operation at a time is granted and issued to the unit. The
// result, or a NaR error on an invalid op or a timeout, is returned to the
// granted requester over a valid/ready response.
module pau_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int PAU_N       = 32,
    parameter int WAIT_CYCLES = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [3*NUM_REQ-1:0]     req_op,
    input  logic [PAU_N*NUM_REQ-1:0] req_a,
    input  logic [PAU_N*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [PAU_N-1:0]         resp_data,
    output logic                     resp_err,
    output logic                     pau_start,
    output logic [1:0]               pau_sel,
    output logic [PAU_N-1:0]         pau_a,
    output logic [PAU_N-1:0]         pau_b,
    input  logic                     pau_done,
    input  logic [PAU_N-1:0]         pau_add,
    input  logic [PAU_N-1:0]         pau_mul,
    input  logic [PAU_N-1:0]         pau_div
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int OP_W  = 3;
    localparam logic [PAU_N-1:0] NAR = {1'b1, {(PAU_N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, RESP = 2'b10} state_t;

    state_t             state_r, state_nxt_s;
    logic [IDX_W-1:0]   rr_ptr_r, gnt_r, gnt_idx_s;
    logic               gnt_found_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [OP_W-1:0]    sel_op_s;
    logic [PAU_N-1:0]   sel_a_s, sel_b_s;
    logic               op_valid_s, op_sub_s;
    logic [1:0]         op_sel_s;
    logic               done_ok_s, timeout_s;
    logic [PAU_N-1:0]   pau_a_r, pau_b_r, resp_data_r, unit_res_s;
    logic [1:0]         pau_sel_r;
    logic               resp_err_r;

    // Wrap-around two's-complement negation; 0 and NaR map onto themselves.
    function automatic logic [PAU_N-1:0] twos_neg(input logic [PAU_N-1:0] v);
        return ~v + {{(PAU_N-1){1'b0}}, 1'b1};
    endfunction

    // Requester index at offset k above the round-robin pointer, with wrap.
    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] ptr, input int k);
        int s;
        s = int'(ptr) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end else begin
            s = s;
        end
        return IDX_W'(s);
    endfunction

    // Round-robin search: first valid requester at or above rr_ptr.
    always_comb begin
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_found_s && req_valid[rr_idx(rr_ptr_r, k)]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = rr_idx(rr_ptr_r, k);
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
    end

    // Select the winner's op/operands and decode the op into unit select.
    always_comb begin
        sel_op_s   = req_op[OP_W*int'(gnt_idx_s) +: OP_W];
        sel_a_s    = req_a[PAU_N*int'(gnt_idx_s) +: PAU_N];
        sel_b_s    = req_b[PAU_N*int'(gnt_idx_s) +: PAU_N];
        op_valid_s = 1'b1;
        op_sub_s   = 1'b0;
        op_sel_s   = 2'b00;
        case (sel_op_s)
            3'b000:  op_sel_s = 2'b00;
            3'b001:  begin op_sel_s = 2'b00; op_sub_s = 1'b1; end
            3'b010:  op_sel_s = 2'b01;
            3'b011:  op_sel_s = 2'b10;
            default: op_valid_s = 1'b0;
        endcase
    end

    // Result of the unit chosen for the operation in flight.
    always_comb begin
        unit_res_s = NAR;
        case (pau_sel_r)
            2'b00:   unit_res_s = pau_add;
            2'b01:   unit_res_s = pau_mul;
            2'b10:   unit_res_s = pau_div;
            default: unit_res_s = NAR;
        endcase
    end

    assign done_ok_s = (cnt_r >= CNT_W'(WAIT_CYCLES)) && pau_done;
    assign timeout_s = (cnt_r == CNT_W'(TIMEOUT));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (gnt_found_s) begin
                    state_nxt_s = op_valid_s ? BUSY : RESP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (done_ok_s || timeout_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            RESP: begin
                if (resp_ready[gnt_r]) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Outputs decoded from state; req_ready is the live arbitration result.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        pau_start  = 1'b0;
        case (state_r)
            IDLE: begin
                if (gnt_found_s) begin
                    req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx_s;
                end else begin
                    req_ready = '0;
                end
            end
            BUSY:    pau_start  = 1'b1;
            RESP:    resp_valid = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_r;
            default: pau_start  = 1'b0;
        endcase
    end

    // Operand latch, settle counter, result capture and pointer advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r    <= '0;
            gnt_r       <= '0;
            cnt_r       <= '0;
            pau_a_r     <= '0;
            pau_b_r     <= '0;
            pau_sel_r   <= 2'b00;
            resp_data_r <= '0;
            resp_err_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (gnt_found_s) begin
                        gnt_r     <= gnt_idx_s;
                        pau_a_r   <= sel_a_s;
                        pau_b_r   <= op_sub_s ? twos_neg(sel_b_s) : sel_b_s;
                        pau_sel_r <= op_sel_s;
                        cnt_r     <= '0;
                        if (!op_valid_s) begin
                            resp_data_r <= NAR;
                            resp_err_r  <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_r != {CNT_W{1'b1}}) begin
                        cnt_r <= cnt_r + CNT_W'(1'b1);
                    end
                    if (done_ok_s) begin
                        resp_data_r <= unit_res_s;
                        resp_err_r  <= 1'b0;
                    end else if (timeout_s) begin
                        resp_data_r <= NAR;
                        resp_err_r  <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready[gnt_r]) begin
                        rr_ptr_r <= (gnt_r == IDX_W'(NUM_REQ-1)) ? '0 : gnt_r + IDX_W'(1'b1);
                    end
                end
                default: cnt_r <= '0;
            endcase
        end
    end

    assign pau_a     = pau_a_r;
    assign pau_b     = pau_b_r;
    assign pau_sel   = pau_sel_r;
    assign resp_data = resp_data_r;
    assign resp_err  = resp_err_r;

endmodule
